// File: rtl/regfile_pkg.sv
// Shared register-file constants, the dump-walker state type and the index
// stepping helper used by regfile_dump_reader.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

  // Wrap modulo NUM_REGS; with x0 skipping, a wrap to 0 lands on 1 instead.
  function automatic logic [ADDR_W-1:0] next_idx(input logic [ADDR_W-1:0] cur,
                                                 input logic              skip_x0);
    logic [ADDR_W-1:0] n;
    n = cur + 1'b1;
    if (skip_x0 && (n == '0)) begin
      n = {{(ADDR_W-1){1'b0}}, 1'b1};
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks an inclusive, wrap-capable register index range on the second read
// port and streams one captured word per register over valid/ready.
module regfile_dump_reader #(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter bit SKIP_X0  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              busy,
  output logic              done
);

  import regfile_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_index_q, out_index_d;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    end_d       = end_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          end_d   = end_addr;
          cur_d   = start_addr;
          state_d = READ;
          // With x0 skipped, a walk starting at 0 begins at 1; 0..0 is empty.
          if (SKIP_X0 && (start_addr == '0)) begin
            cur_d = ONE_IDX;
            if (end_addr == '0) begin
              state_d = DONE;
            end
          end
        end
      end

      READ: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          out_data_d  = rd_data;
          out_index_d = cur_q;
          state_d     = SEND;
        end
      end

      SEND: begin
        if (abort) begin
          state_d = IDLE;
        end else if (out_ready) begin
          if (cur_q == end_q) begin
            state_d = DONE;
          end else begin
            cur_d   = next_idx(cur_q, SKIP_X0);
            state_d = READ;
            // Wrapping past the top with end at 0 means the skipped x0 was last.
            if (SKIP_X0 && (cur_q == LAST_IDX) && (end_q == '0)) begin
              state_d = DONE;
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      end_q       <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      end_q       <= end_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
    end
  end

  // All outputs decode from registered state only, so out_ready never
  // reaches out_valid combinationally.
  assign rd_addr   = (state_q == READ) ? cur_q : '0;
  assign out_valid = (state_q == SEND);
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule
